// File: rtl/i8080_write_rx_pkg.sv
// Shared types and constants for the i8080 write receiver (MCU bus to RGB565 FIFO).
package i8080_pkg;

  localparam int WORD_W = 16;

  localparam logic [7:0] CMD_RAMWR_DEF  = 8'h2C;
  localparam logic [7:0] CMD_RAMWRC_DEF = 8'h3C;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PARAM = 2'd1,
    MEMWR = 2'd2
  } state_e;

endpackage

// File: rtl/i8080_write_rx_if.sv
// i8080 (8080-II, 8-bit) write-side bus pins; the MCU is the master.
interface i8080_write_rx_if;
  logic       I80_nCS;
  logic       I80_nWR;
  logic       I80_DC;
  logic [7:0] I80_D;

  modport master (output I80_nCS, output I80_nWR, output I80_DC, output I80_D);
  modport slave  (input  I80_nCS, input  I80_nWR, input  I80_DC, input  I80_D);
endinterface

// File: rtl/i8080_write_rx_sync_edge.sv
// Multi-flop synchroniser for a bus of WIDTH bits with rising-edge detect on bit 0.
module i8080_sync_edge #(
  parameter int               STAGES  = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync_o,
  output logic             rise_o
);

  logic [STAGES-1:0][WIDTH-1:0] chain_q, chain_d;
  logic                         prev_q, prev_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], din};
    prev_d  = chain_q[STAGES-1][0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {STAGES{RST_VAL}};
      prev_q  <= RST_VAL[0];
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = chain_q[STAGES-1][0] & ~prev_q;

endmodule

// File: rtl/i8080_write_rx.sv
// i8080 write receiver: decodes commands/parameters and packs RAMWR byte pairs into RGB565 words.
// Build option I80_BYTE_SWAP_EN: first byte of each pair becomes the low byte.
module i8080_write_rx
  import i8080_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CMD_RAMWR   = CMD_RAMWR_DEF,
  parameter logic [7:0] CMD_RAMWRC  = CMD_RAMWRC_DEF
) (
  input  logic                CLK,
  input  logic                nRST,
  i8080_write_rx_if.slave     bus,
  input  logic                FIFO_FULL,
  output logic                FIFO_WE,
  output logic [WORD_W-1:0]   FIFO_DI,
  output logic                FRAME_START,
  output logic                CMD_VALID,
  output logic [7:0]          CMD_CODE,
  output logic                PARAM_VALID,
  output logic [7:0]          PARAM_DATA,
  output logic                OVERFLOW,
  output state_e              DBG_STATE
);

  // nWR, DC and D share one chain so the byte is always aligned with its strobe.
  logic [9:0] dwr_sync;
  logic       nwr_rise;
  logic [0:0] ncs_sync;
  logic       ncs_rise;

  i8080_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(10), .RST_VAL(10'h001)) u_sync_dwr (
    .clk    (CLK),
    .rst_n  (nRST),
    .din    ({bus.I80_D, bus.I80_DC, bus.I80_nWR}),
    .sync_o (dwr_sync),
    .rise_o (nwr_rise)
  );

  i8080_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b1)) u_sync_ncs (
    .clk    (CLK),
    .rst_n  (nRST),
    .din    (bus.I80_nCS),
    .sync_o (ncs_sync),
    .rise_o (ncs_rise)
  );

  // Capture stage: one registered write event with its byte and DC.
  logic       wr_evt_q, wr_evt_d;
  logic       ncs_rise_q, ncs_rise_d;
  logic       dc_q, dc_d;
  logic [7:0] byte_q, byte_d;

  // Decode state and registered outputs.
  state_e            state_q, state_d;
  logic              phase_q, phase_d;
  logic [7:0]        first_q, first_d;
  logic              fifo_we_q, fifo_we_d;
  logic [WORD_W-1:0] fifo_di_q, fifo_di_d;
  logic              frame_start_q, frame_start_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [7:0]        cmd_code_q, cmd_code_d;
  logic              param_valid_q, param_valid_d;
  logic [7:0]        param_data_q, param_data_d;
  logic              overflow_q, overflow_d;

  always_comb begin
    wr_evt_d   = nwr_rise & dwr_sync[0] & ~ncs_sync[0];
    ncs_rise_d = ncs_rise;
    dc_d       = dwr_sync[1];
    byte_d     = dwr_sync[9:2];
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    first_d       = first_q;
    fifo_we_d     = 1'b0;
    fifo_di_d     = fifo_di_q;
    frame_start_d = 1'b0;
    cmd_valid_d   = 1'b0;
    cmd_code_d    = cmd_code_q;
    param_valid_d = 1'b0;
    param_data_d  = param_data_q;
    overflow_d    = overflow_q;

    // An nCS release drops any odd byte but keeps the state for the next session.
    if (ncs_rise_q) phase_d = 1'b0;

    if (wr_evt_q) begin
      if (!dc_q) begin
        cmd_valid_d = 1'b1;
        cmd_code_d  = byte_q;
        phase_d     = 1'b0;
        if (byte_q == CMD_RAMWR) begin
          state_d       = MEMWR;
          frame_start_d = 1'b1;
          overflow_d    = 1'b0;
        end else if (byte_q == CMD_RAMWRC) begin
          state_d = MEMWR;
        end else begin
          state_d = PARAM;
        end
      end else if (state_q != MEMWR) begin
        param_valid_d = 1'b1;
        param_data_d  = byte_q;
      end else if (!phase_q) begin
        first_d = byte_q;
        phase_d = 1'b1;
      end else begin
`ifdef I80_BYTE_SWAP_EN
        fifo_di_d = {byte_q, first_q};
`else
        fifo_di_d = {first_q, byte_q};
`endif
        if (FIFO_FULL) overflow_d = 1'b1;
        else           fifo_we_d  = 1'b1;
        phase_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_evt_q      <= 1'b0;
      ncs_rise_q    <= 1'b0;
      dc_q          <= 1'b0;
      byte_q        <= '0;
      state_q       <= IDLE;
      phase_q       <= 1'b0;
      first_q       <= '0;
      fifo_we_q     <= 1'b0;
      fifo_di_q     <= '0;
      frame_start_q <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= '0;
      param_valid_q <= 1'b0;
      param_data_q  <= '0;
      overflow_q    <= 1'b0;
    end else begin
      wr_evt_q      <= wr_evt_d;
      ncs_rise_q    <= ncs_rise_d;
      dc_q          <= dc_d;
      byte_q        <= byte_d;
      state_q       <= state_d;
      phase_q       <= phase_d;
      first_q       <= first_d;
      fifo_we_q     <= fifo_we_d;
      fifo_di_q     <= fifo_di_d;
      frame_start_q <= frame_start_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_code_q    <= cmd_code_d;
      param_valid_q <= param_valid_d;
      param_data_q  <= param_data_d;
      overflow_q    <= overflow_d;
    end
  end

  assign FIFO_WE     = fifo_we_q;
  assign FIFO_DI     = fifo_di_q;
  assign FRAME_START = frame_start_q;
  assign CMD_VALID   = cmd_valid_q;
  assign CMD_CODE    = cmd_code_q;
  assign PARAM_VALID = param_valid_q;
  assign PARAM_DATA  = param_data_q;
  assign OVERFLOW    = overflow_q;
  assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_i8080_write_rx.sv
// Directed bench for i8080_write_rx: expected words/commands/params are queued by the driver, popped by a monitor.
module tb_i8080_write_rx;
  import i8080_pkg::*;

  localparam int SYNC = 2;

  logic        clk;
  logic        rst_n;
  logic        fifo_full;
  logic        fifo_we;
  logic [15:0] fifo_di;
  logic        frame_start;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic        param_valid;
  logic [7:0]  param_data;
  logic        overflow;
  state_e      dbg_state;

  i8080_write_rx_if bus_if ();

  i8080_write_rx #(.SYNC_STAGES(SYNC)) dut (
    .CLK         (clk),
    .nRST        (rst_n),
    .bus         (bus_if.slave),
    .FIFO_FULL   (fifo_full),
    .FIFO_WE     (fifo_we),
    .FIFO_DI     (fifo_di),
    .FRAME_START (frame_start),
    .CMD_VALID   (cmd_valid),
    .CMD_CODE    (cmd_code),
    .PARAM_VALID (param_valid),
    .PARAM_DATA  (param_data),
    .OVERFLOW    (overflow),
    .DBG_STATE   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [15:0] exp_q[$];
  logic [7:0]  exp_cmd_q[$];
  logic [7:0]  exp_param_q[$];
  int checks = 0;
  int errors = 0;
  int frame_cnt = 0;
  int exp_frame_cnt = 0;
  int last_rise_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic [7:0] first, input logic [7:0] second);
`ifdef I80_BYTE_SWAP_EN
    return {second, first};
`else
    return {first, second};
`endif
  endfunction

  // driver tasks
  task automatic write_byte(input logic dc, input logic [7:0] d);
    @(posedge clk); #1;
    bus_if.I80_DC  = dc;
    bus_if.I80_D   = d;
    bus_if.I80_nWR = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus_if.I80_nWR = 1'b1;
    last_rise_cyc  = cyc;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    exp_cmd_q.push_back(c);
    if (c == 8'h2C) exp_frame_cnt++;
    write_byte(1'b0, c);
  endtask

  task automatic send_param(input logic [7:0] p);
    exp_param_q.push_back(p);
    write_byte(1'b1, p);
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic [15:0] w);
    write_byte(1'b1, a);
    exp_q.push_back(w);
    write_byte(1'b1, b);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fifo_we"},     fifo_we,     0);
    check({tag, "_fifo_di"},     fifo_di,     0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_cmd_valid"},   cmd_valid,   0);
    check({tag, "_cmd_code"},    cmd_code,    0);
    check({tag, "_param_valid"}, param_valid, 0);
    check({tag, "_param_data"},  param_data,  0);
    check({tag, "_overflow"},    overflow,    0);
    check({tag, "_state"},       dbg_state,   IDLE);
  endtask

  // monitor: pops expected values whenever the DUT pulses an output
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_we) begin
        if (exp_q.size() == 0) begin
          check("fifo_we_unexpected", {16'h0, fifo_di}, 32'hFFFF_FFFF);
        end else begin
          check("fifo_di", fifo_di, exp_q.pop_front());
          check("fifo_we_latency", cyc - last_rise_cyc, SYNC + 2);
        end
      end
      if (cmd_valid) begin
        if (exp_cmd_q.size() == 0) check("cmd_valid_unexpected", cmd_code, 32'hFFFF_FFFF);
        else                        check("cmd_code", cmd_code, exp_cmd_q.pop_front());
      end
      if (param_valid) begin
        if (exp_param_q.size() == 0) check("param_valid_unexpected", param_data, 32'hFFFF_FFFF);
        else                          check("param_data", param_data, exp_param_q.pop_front());
      end
      if (frame_start) frame_cnt++;
    end
  end

  initial begin
    logic [7:0] b0, b1;
    rst_n           = 1'b0;
    fifo_full       = 1'b0;
    bus_if.I80_nCS  = 1'b1;
    bus_if.I80_nWR  = 1'b1;
    bus_if.I80_DC   = 1'b0;
    bus_if.I80_D    = 8'h00;
    wait_cycles(4);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_cycles(3);

    // RAMWR then one pixel
    bus_if.I80_nCS = 1'b0;
    send_cmd(8'h2C);
`ifdef I80_BYTE_SWAP_EN
    b0 = 8'h00; b1 = 8'hF8;
`else
    b0 = 8'hF8; b1 = 8'h00;
`endif
    send_pair(b0, b1, 16'hF800);
    check("t1_overflow", overflow, 0);
    check("t1_state", dbg_state, MEMWR);
    check("t1_frames", frame_cnt, 1);

    // column address command with four parameters
    send_cmd(8'h2A);
    send_param(8'h00);
    send_param(8'h00);
    send_param(8'h01);
    send_param(8'h3F);
    check("t2_cmd_code", cmd_code, 8'h2A);
    check("t2_param_data", param_data, 8'h3F);
    check("t2_state", dbg_state, PARAM);

    // odd byte dropped by nCS release, state kept across sessions
    send_cmd(8'h2C);
    send_pair(8'h12, 8'h34, exp_word(8'h12, 8'h34));
    write_byte(1'b1, 8'h56);
    bus_if.I80_nCS = 1'b1;
    wait_cycles(5);
    check("t3_state_kept", dbg_state, MEMWR);
    bus_if.I80_nCS = 1'b0;
    wait_cycles(2);
    send_pair(8'h78, 8'h9A, exp_word(8'h78, 8'h9A));

    // FIFO full drops the word and sets sticky overflow
    fifo_full = 1'b1;
    write_byte(1'b1, 8'hAA);
    write_byte(1'b1, 8'hBB);
    fifo_full = 1'b0;
    check("t4_overflow_set", overflow, 1);
    send_cmd(8'h3C);
    check("t4_overflow_after_3c", overflow, 1);
    check("t4_state_3c", dbg_state, MEMWR);
    send_pair(8'hC1, 8'hC2, exp_word(8'hC1, 8'hC2));
    send_cmd(8'h2C);
    check("t4_overflow_cleared", overflow, 0);

    // writes with nCS high are ignored
    bus_if.I80_nCS = 1'b1;
    wait_cycles(3);
    send_pair_ignored();
    check("t5_state", dbg_state, MEMWR);
    check("t5_cmd_code", cmd_code, 8'h2C);

    // reset in the middle of a pixel pair
    bus_if.I80_nCS = 1'b0;
    wait_cycles(2);
    write_byte(1'b1, 8'hDE);
    @(posedge clk); #1;
    bus_if.I80_D   = 8'hAD;
    bus_if.I80_nWR = 1'b0;
    wait_cycles(1);
    rst_n = 1'b0;
    wait_cycles(2);
    check_reset_outputs("midreset");
    bus_if.I80_nWR = 1'b1;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(10);
    check("t6_state_idle", dbg_state, IDLE);
    send_param(8'h55);
    check("t6_param_data", param_data, 8'h55);

    wait_cycles(5);
    check("end_words_left", exp_q.size(), 0);
    check("end_cmds_left", exp_cmd_q.size(), 0);
    check("end_params_left", exp_param_q.size(), 0);
    check("end_frame_starts", frame_cnt, exp_frame_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic send_pair_ignored();
    write_byte(1'b0, 8'h2C);
    write_byte(1'b1, 8'h11);
    write_byte(1'b1, 8'h22);
  endtask

endmodule

// File: doc/i8080_write_rx.md
Name: i8080_write_rx

Overview:
- Upstream stage of the LCD bridge. Receives MCU i8080 (8080-II, 8-bit) write cycles and decodes command and parameter bytes.
- During memory-write bursts, packs byte pairs into 16-bit RGB565 words and pushes them into the display FIFO write port.
- Single clock domain (the 100 MHz FIFO write clock). All bus pins are asynchronous and are synchronised internally.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers (minimum 2).
- CMD_RAMWR, 8'h2C, command that starts a new frame memory write.
- CMD_RAMWRC, 8'h3C, command that continues a memory write without starting a new frame.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- I80_nCS  input  1  chip select, active low, asynchronous.
- I80_nWR  input  1  write strobe, active low; data is captured on its rising edge.
- I80_DC  input  1  0 = command byte, 1 = data/parameter byte.
- I80_D  input  8  bus data.
- FIFO_FULL  input  1  FIFO full flag.
- FIFO_WE  output  1  one-cycle write pulse.
- FIFO_DI  output  16  RGB565 pixel word.
- FRAME_START  output  1  one-cycle pulse on accepted CMD_RAMWR.
- CMD_VALID  output  1  one-cycle pulse for any command byte.
- CMD_CODE  output  8  last command byte; held until the next command.
- PARAM_VALID  output  1  one-cycle pulse for a parameter byte received outside a memory write.
- PARAM_DATA  output  8  last parameter byte.
- OVERFLOW  output  1  sticky; set when a pixel is dropped because the FIFO is full.

Behaviour:
- Reset: all outputs 0, state IDLE, byte phase 0, synchronisers cleared (nCS/nWR sync chains reset to 1).
- nCS, nWR, DC and D each pass through SYNC_STAGES flops with identical depth, so data stays aligned with its strobe.
- Write event: cycle in which the synchronised nWR is 1, its previous value is 0, and the synchronised nCS is 0. Byte and DC are taken from the same pipeline stage.
- Bus timing requirement: nWR low ≥ 2 CLK, nWR high ≥ 2 CLK, data stable ≥ 1 CLK after the nWR rising edge.
- All outputs are registered. Pulses assert in the cycle after the write event and last exactly 1 cycle.
- Total latency from pin edge to FIFO_WE: SYNC_STAGES+2 cycles.
- States: IDLE, PARAM, MEMWR.
  - Any state, DC=0 byte: CMD_VALID pulse and CMD_CODE updated; byte phase cleared.
  - Command CMD_RAMWR: go to MEMWR and pulse FRAME_START.
  - Command CMD_RAMWRC: go to MEMWR without FRAME_START.
  - Any other command: go to PARAM.
  - PARAM or IDLE, DC=1 byte: PARAM_VALID pulse and PARAM_DATA updated; state unchanged.
  - MEMWR, DC=1 byte, phase 0: latch byte as the high byte; phase becomes 1.
  - MEMWR, DC=1 byte, phase 1: FIFO_DI = {high, current}.
    - FIFO_FULL=0: FIFO_WE pulses.
    - FIFO_FULL=1: word dropped, OVERFLOW set, FIFO_WE stays 0.
    - Phase returns to 0 in both cases.
- nCS deassertion (synchronised 0→1): byte phase cleared and any odd pending byte is discarded. State is retained, so the next nCS session continues the memory write.
- FIFO_FULL is sampled in the same cycle as the second-byte write event.
- OVERFLOW clears only on nRST or on an accepted CMD_RAMWR.
- Reset mid-burst: immediate return to reset values. A partially assembled word is lost and no FIFO_WE is emitted.
- Write events with the synchronised nCS=1 are ignored entirely.

Optional Feature:
- Macro I80_BYTE_SWAP_EN.
  - Defined: first byte of each pair is the low byte; FIFO_DI = {current, first}.
  - Undefined: first byte is the high byte (default, as above).
- Command, parameter and overflow behaviour are identical in both builds.

Decomposition:
- Package i8080_pkg holds:
  - state enum (IDLE, PARAM, MEMWR);
  - default command constants 8'h2C and 8'h3C;
  - RGB565 word width 16.
- One sub-module is natural: i8080_sync_edge (parameterised synchroniser plus rising-edge detector), instantiated for nWR and nCS.
- DC and D use the plain synchroniser path of the same module.

Test Plan:
- Reset, then command 0x2C followed by data bytes 0xF8, 0x00 → FRAME_START 1 pulse; FIFO_WE exactly 1 pulse with FIFO_DI=16'hF800; OVERFLOW=0.
- Command 0x2A, then params 0x00, 0x00, 0x01, 0x3F → CMD_CODE=0x2A, 4 PARAM_VALID pulses with final PARAM_DATA=0x3F; FIFO_WE never asserts.
- MEMWR burst of 3 bytes 0x12, 0x34, 0x56, nCS high, nCS low, then bytes 0x78, 0x9A → words 16'h1234 and 16'h789A only; 0x56 is discarded.
- FIFO_FULL held at 1 during the second byte of a pair → no FIFO_WE and OVERFLOW=1. OVERFLOW remains 1 after command 0x3C; a new 0x2C clears it.
- Toggle nWR while nCS=1 with DC=0 and D=0x2C → no pulses, state unchanged. Then assert nRST low mid-pair → all outputs 0 and no FIFO_WE after release.
- Build with I80_BYTE_SWAP_EN, send 0x2C followed by bytes 0x00, 0xF8 → FIFO_DI=16'hF800.
